// File: rtl/wbm_burst_initiator_if.sv
// Bundle of the command, write-data, read-data, Wishbone master and status
// signals of the burst initiator. The master modport is the initiator's view;
// the slave modport is the view of whatever drives commands and answers the bus.
interface wbm_burst_initiator_if #(
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [31:0]      cmd_adr;
  logic [LEN_W-1:0] cmd_len;

  logic             wd_valid;
  logic             wd_ready;
  logic [31:0]      wd_data;

  logic             rd_valid;
  logic             rd_ready;
  logic [31:0]      rd_data;

  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o;
  logic [31:0]      wbm_dat_o;
  logic             wbm_ack_i;
  logic [31:0]      wbm_dat_i;

  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_len,
    output cmd_ready,
    input  wd_valid, wd_data,
    output wd_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_len,
    input  cmd_ready,
    output wd_valid, wd_data,
    input  wd_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i,
    input  busy, done, err
  );
endinterface

// File: rtl/wbm_burst_initiator.sv
// Wishbone classic initiator. Each accepted command becomes cmd_len+1
// single-word transfers at consecutive word addresses, all inside one bus
// cycle (cyc held). Write words are pulled from the wd stream one per beat;
// read words are pushed onto the rd stream and must be popped before the next
// beat is issued. A beat that waits TIMEOUT_CYC+1 strobe cycles without ack
// aborts the burst and reports err with done.
//
// state | meaning
// IDLE  | no burst; cmd_ready high, waiting for a command
// WDATA | inside the bus cycle, waiting for the next write word (stb low)
// REQ   | stb high, waiting for ack or timeout
// RESP  | read word held on rd stream until popped (stb low, cyc high)
// FIN   | cyc low, one-cycle done pulse, err shows the outcome
module wbm_burst_initiator #(
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wbm_burst_initiator_if.master bus
);

  localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_REQ,
    S_RESP,
    S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_we;
  logic [31:0]      r_adr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat;
  logic [TMO_W-1:0] r_tmo;
  logic [31:0]      r_dat_o;
  logic [31:0]      r_rd_data;
  logic             r_rd_valid;
  logic             r_err;

  logic             w_last;
  logic             w_accept;
  logic             w_wd_take;
  logic             w_rd_capture;
  logic             w_pop;
  logic             w_step;
  logic             w_abort;
  logic             w_cyc;

  assign w_last = (r_beat == r_len);
  assign w_cyc  = (r_state == S_WDATA) || (r_state == S_REQ) || (r_state == S_RESP);

  // State register; a synchronous reset abandons any burst without a done pulse.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and the single-cycle datapath strobes that go with it.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_wd_take    = 1'b0;
    w_rd_capture = 1'b0;
    w_pop        = 1'b0;
    w_step       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = bus.cmd_we ? S_WDATA : S_REQ;
        end
      end
      S_WDATA: begin
        if (bus.wd_valid) begin
          w_wd_take   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // ack takes priority over a timeout landing on the same cycle
        if (bus.wbm_ack_i) begin
          if (!r_we) begin
            w_rd_capture = 1'b1;
            w_state_nxt  = S_RESP;
          end else if (w_last) begin
            w_state_nxt = S_FIN;
          end else begin
            w_step      = 1'b1;
            w_state_nxt = S_WDATA;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_RESP: begin
        if (bus.rd_ready) begin
          w_pop = 1'b1;
          if (w_last) begin
            w_state_nxt = S_FIN;
          end else begin
            w_step      = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Burst context: direction, word address, beat count, outgoing word, error flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we    <= 1'b0;
      r_adr   <= 32'd0;
      r_len   <= '0;
      r_beat  <= '0;
      r_dat_o <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we   <= bus.cmd_we;
        r_adr  <= bus.cmd_adr & ~32'd3;
        r_len  <= bus.cmd_len;
        r_beat <= '0;
        r_err  <= 1'b0;
      end
      if (w_wd_take) begin
        r_dat_o <= bus.wd_data;
      end
      // address wraps modulo 2^32 by plain overflow
      if (w_step) begin
        r_adr  <= r_adr + 32'd4;
        r_beat <= r_beat + LEN_W'(1);
      end
      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  // Read-data holding register; stays put until the consumer pops it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_rd_data  <= 32'd0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_rd_capture) begin
        r_rd_data  <= bus.wbm_dat_i;
        r_rd_valid <= 1'b1;
      end else if (w_pop) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  // Ack-wait timer: held at zero outside REQ so every strobe starts from zero.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tmo <= '0;
    end else if (r_state != S_REQ) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.wd_ready  = (r_state == S_WDATA);
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.wbm_cyc_o = w_cyc;
  assign bus.wbm_stb_o = (r_state == S_REQ);
  assign bus.wbm_we_o  = w_cyc & r_we;
  assign bus.wbm_sel_o = 4'hF;
  assign bus.wbm_adr_o = r_adr;
  assign bus.wbm_dat_o = r_dat_o;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_FIN);
  assign bus.err       = r_err;

endmodule

// File: tb/tb_wbm_burst_initiator.sv
// Bench for wbm_burst_initiator: a transaction-level model of the burst
// (beats left, pending write word, pending read word, error flag) is checked
// against the DUT on every cycle; directed bursts then pin observed addresses,
// data and strobe lengths to hand-computed literals.
module tb_wbm_burst_initiator;
  localparam int LEN_W = 4;
  localparam int TMO   = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wbm_burst_initiator_if #(.LEN_W(LEN_W)) bus();

  wbm_burst_initiator #(.LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.master)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: wait bound expired, got none expected event", name);
  endtask

  // slave and write-data source controls
  typedef struct {logic [31:0] data; int gap;} wd_t;
  wd_t         wd_q[$];
  logic [31:0] s_rd_q[$];
  int          s_wait  = 1;
  bit          s_hang  = 1'b0;
  bit          s_stray = 1'b0;

  // observations
  logic [31:0] obs_adr[$];
  logic [31:0] obs_dat[$];
  logic [31:0] obs_rd[$];
  int          obs_runs[$];
  int          o_run    = 0;
  int          done_cnt = 0;
  logic        last_err = 1'b0;

  // model
  bit          chk_en   = 1'b0;
  bit          m_active = 1'b0;
  bit          m_fin    = 1'b0;
  bit          m_rdv    = 1'b0;
  bit          m_need_wd = 1'b0;
  bit          m_errreg = 1'b0;
  bit          m_we     = 1'b0;
  logic [31:0] m_adr    = 32'd0;
  logic [31:0] m_wd     = 32'd0;
  logic [31:0] m_rdexp  = 32'd0;
  int          m_left   = 0;
  int          m_run    = 0;

  // slave: acks after s_wait strobe cycles, returns queued read words
  initial begin
    int s_cnt;
    s_cnt = 0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wbm_stb_o && !s_hang && !rst) begin
        if (s_cnt >= s_wait) begin
          bus.wbm_ack_i = 1'b1;
          if (!bus.wbm_we_o) bus.wbm_dat_i = (s_rd_q.size() > 0) ? s_rd_q.pop_front() : 32'd0;
        end else begin
          s_cnt++;
          bus.wbm_ack_i = 1'b0;
        end
      end else begin
        s_cnt = 0;
        bus.wbm_ack_i = s_stray;
      end
    end
  end

  // write-data source: each word waits its gap cycles before being offered
  initial begin
    bit took;
    bit g_loaded;
    int g_cnt;
    g_loaded = 1'b0;
    g_cnt = 0;
    bus.wd_valid = 1'b0;
    bus.wd_data  = 32'd0;
    forever begin
      @(negedge clk);
      took = bus.wd_valid && bus.wd_ready && !rst;
      @(posedge clk);
      #1;
      if (took) begin
        void'(wd_q.pop_front());
        g_loaded = 1'b0;
      end
      if (wd_q.size() > 0) begin
        if (!g_loaded) begin
          g_cnt = wd_q[0].gap;
          g_loaded = 1'b1;
        end
        if (g_cnt > 0) begin
          g_cnt--;
          bus.wd_valid = 1'b0;
        end else begin
          bus.wd_valid = 1'b1;
          bus.wd_data  = wd_q[0].data;
        end
      end else begin
        bus.wd_valid = 1'b0;
      end
    end
  end

  // per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc", bus.wbm_cyc_o, m_active);
      chk("stb", bus.wbm_stb_o, m_active && !m_need_wd && !m_rdv);
      chk("wd_ready", bus.wd_ready, m_need_wd);
      chk("rd_valid", bus.rd_valid, m_rdv);
      chk("done", bus.done, m_fin);
      chk("err", bus.err, m_errreg);
      chk("busy", bus.busy, m_active || m_fin);
      chk("cmd_ready", bus.cmd_ready, !(m_active || m_fin));
      if (bus.wbm_cyc_o) chk("sel", bus.wbm_sel_o, 4'hF);
      if (m_active && !m_need_wd && !m_rdv) begin
        chk("adr", bus.wbm_adr_o, m_adr);
        chk("we", bus.wbm_we_o, m_we);
        if (m_we) chk("dat_o", bus.wbm_dat_o, m_wd);
      end
      if (m_rdv) chk("rd_data", bus.rd_data, m_rdexp);

      if (bus.wbm_stb_o) o_run++;
      else if (o_run > 0) begin
        obs_runs.push_back(o_run);
        o_run = 0;
      end
      if (bus.done) begin
        done_cnt++;
        last_err = bus.err;
      end

      if (rst) begin
        m_active = 0; m_fin = 0; m_rdv = 0; m_need_wd = 0; m_errreg = 0; m_run = 0;
      end else if (m_fin) begin
        m_fin = 0;
      end else if (!m_active) begin
        if (bus.cmd_valid) begin
          m_active  = 1;
          m_we      = bus.cmd_we;
          m_adr     = bus.cmd_adr & ~32'd3;
          m_left    = int'(bus.cmd_len) + 1;
          m_errreg  = 0;
          m_need_wd = bus.cmd_we;
          m_rdv     = 0;
          m_run     = 0;
        end
      end else if (m_need_wd) begin
        if (bus.wd_valid) begin
          m_need_wd = 0;
          m_wd      = bus.wd_data;
          m_run     = 0;
        end
      end else if (m_rdv) begin
        if (bus.rd_ready) begin
          obs_rd.push_back(bus.rd_data);
          m_rdv = 0;
          m_left--;
          if (m_left == 0) begin
            m_active = 0; m_fin = 1;
          end else begin
            m_adr = m_adr + 32'd4;
          end
          m_run = 0;
        end
      end else begin
        if (bus.wbm_ack_i) begin
          obs_adr.push_back(bus.wbm_adr_o);
          if (m_we) begin
            obs_dat.push_back(bus.wbm_dat_o);
            m_left--;
            if (m_left == 0) begin
              m_active = 0; m_fin = 1;
            end else begin
              m_adr = m_adr + 32'd4;
              m_need_wd = 1;
            end
          end else begin
            m_rdv   = 1;
            m_rdexp = bus.wbm_dat_i;
          end
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == TMO + 1) begin
            m_active = 0; m_fin = 1; m_errreg = 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit we, input logic [31:0] adr, input int len);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_len   = LEN_W'(len);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("cmd_accept");
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start;
    start = done_cnt;
    for (int t = 0; t < budget && done_cnt == start; t++) step();
    if (done_cnt == start) fail_now(name);
  endtask

  initial begin
    int a0, d0, r0, n0, dc;
    bit seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'd0;
    bus.cmd_len   = '0;
    bus.rd_ready  = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_cyc", bus.wbm_cyc_o, 0);
    chk("rst_stb", bus.wbm_stb_o, 0);
    chk("rst_adr", bus.wbm_adr_o, 32'd0);
    chk("rst_dat", bus.wbm_dat_o, 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    step();
    rst = 1'b0;
    step();

    // 1: single-beat write
    a0 = obs_adr.size(); d0 = obs_dat.size(); n0 = obs_runs.size();
    wd_q.push_back('{32'hDEAD_BEEF, 0});
    issue(1'b1, 32'h3000_0004, 0);
    wait_done("t1_done", 50);
    step();
    chk("t1_beats", obs_adr.size() - a0, 1);
    chk("t1_adr", obs_adr[a0], 32'h3000_0004);
    chk("t1_dat", obs_dat[d0], 32'hDEAD_BEEF);
    chk("t1_stb_len", obs_runs[n0], 2);
    chk("t1_err", last_err, 0);

    // 2: four-beat read
    a0 = obs_adr.size(); r0 = obs_rd.size();
    s_rd_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    issue(1'b0, 32'h3000_1000, 3);
    wait_done("t2_done", 100);
    step();
    chk("t2_adr0", obs_adr[a0],     32'h3000_1000);
    chk("t2_adr1", obs_adr[a0 + 1], 32'h3000_1004);
    chk("t2_adr2", obs_adr[a0 + 2], 32'h3000_1008);
    chk("t2_adr3", obs_adr[a0 + 3], 32'h3000_100C);
    chk("t2_rd0", obs_rd[r0],     32'h11);
    chk("t2_rd1", obs_rd[r0 + 1], 32'h22);
    chk("t2_rd2", obs_rd[r0 + 2], 32'h33);
    chk("t2_rd3", obs_rd[r0 + 3], 32'h44);

    // 3: read back-pressure
    r0 = obs_rd.size(); n0 = obs_runs.size();
    s_rd_q = '{32'h11, 32'h22};
    bus.rd_ready = 1'b0;
    issue(1'b0, 32'h3000_2000, 1);
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bus.rd_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) fail_now("t3_rd_valid");
    repeat (10) step();
    chk("t3_held", bus.rd_data, 32'h11);
    chk("t3_one_stb", obs_runs.size() - n0, 1);
    bus.rd_ready = 1'b1;
    wait_done("t3_done", 50);
    step();
    chk("t3_two_stb", obs_runs.size() - n0, 2);
    chk("t3_rd0", obs_rd[r0],     32'h11);
    chk("t3_rd1", obs_rd[r0 + 1], 32'h22);

    // 4: timeout, then recovery
    n0 = obs_runs.size(); r0 = obs_rd.size();
    s_hang = 1'b1;
    issue(1'b0, 32'h4000_0000, 0);
    wait_done("t4_done", 400);
    step();
    chk("t4_stb_len", obs_runs[n0], TMO + 1);
    chk("t4_err", last_err, 1);
    chk("t4_err_held", bus.err, 1);
    s_hang = 1'b0;
    s_rd_q = '{32'h55};
    issue(1'b0, 32'h4000_0010, 0);
    chk("t4_err_clear", bus.err, 0);
    wait_done("t4b_done", 50);
    step();
    chk("t4b_err", last_err, 0);
    chk("t4b_rd", obs_rd[r0], 32'h55);

    // 5: write across the address wrap with a write-data gap
    a0 = obs_adr.size(); d0 = obs_dat.size();
    wd_q.push_back('{32'h0000_00A1, 0});
    wd_q.push_back('{32'h0000_00A2, 6});
    issue(1'b1, 32'hFFFF_FFFE, 1);
    wait_done("t5_done", 80);
    step();
    chk("t5_adr0", obs_adr[a0],     32'hFFFF_FFFC);
    chk("t5_adr1", obs_adr[a0 + 1], 32'h0000_0000);
    chk("t5_dat0", obs_dat[d0],     32'h0000_00A1);
    chk("t5_dat1", obs_dat[d0 + 1], 32'h0000_00A2);

    // 6: reset during beat 2 of a four-beat read
    r0 = obs_rd.size();
    s_rd_q = '{32'h61, 32'h62, 32'h63, 32'h64};
    issue(1'b0, 32'h5000_0000, 3);
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (obs_rd.size() == r0 + 1 && bus.wbm_stb_o) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) fail_now("t6_beat2");
    dc = done_cnt;
    rst = 1'b1;
    step();
    chk("t6_cyc", bus.wbm_cyc_o, 0);
    chk("t6_stb", bus.wbm_stb_o, 0);
    step();
    rst = 1'b0;
    s_rd_q.delete();
    repeat (3) step();
    chk("t6_idle", bus.busy, 0);
    chk("t6_no_done", done_cnt, dc);

    // stray ack while idle is ignored
    s_stray = 1'b1;
    repeat (3) step();
    s_stray = 1'b0;
    repeat (2) step();
    chk("stray_idle", bus.busy, 0);
    chk("stray_no_done", done_cnt, dc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run expected finish");
    $fatal(1, "watchdog");
  end

endmodule
